// File: rtl/pad_window3x3.sv
// rtl/pad_window3x3.sv - zero-padded 3x3 stride-1 window generator for one raster pixel lane
// Two line buffers feed a shifting 3x3 register; padding is applied by masking at the output.
module pad_window3x3 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 208
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [9*DATA_WIDTH-1:0] window_out,
  output logic                    valid_out,
  output logic                    frame_done
);

  localparam int AW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int CW = $clog2(IMG_SIZE + 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_SIZE - 1);
  localparam logic [CW-1:0] C_SIZE = CW'(IMG_SIZE);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {S_ROW0, S_RUN, S_EDGE, S_DRAIN} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_row;
  logic [CW-1:0]             r_col;
  logic                      r_ready;
  logic [9*DATA_WIDTH-1:0]   r_win;
  logic [DATA_WIDTH-1:0]     r_lb1 [IMG_SIZE];
  logic [DATA_WIDTH-1:0]     r_lb2 [IMG_SIZE];

  logic                      w_accept;
  logic                      w_step;
  logic                      w_emit;
  logic [AW-1:0]             w_rd_addr;
  logic [3*DATA_WIDTH-1:0]   w_col;
  logic                      w_mask_top;
  logic                      w_mask_left;
  logic                      w_mask_right;
  logic                      w_mask_bot;
  logic [9*DATA_WIDTH-1:0]   w_shift;
  logic [9*DATA_WIDTH-1:0]   w_masked;

  assign ready_out = r_ready;
  assign w_accept  = valid_in & r_ready;
  assign w_step    = w_accept | (r_state == S_EDGE) | (r_state == S_DRAIN);
  assign w_emit    = (w_accept & (r_state == S_RUN) & (r_col != '0)) |
                     (r_state == S_EDGE) | (r_state == S_DRAIN);

  // EDGE preloads column 0 so the first DRAIN step already has its centre column in place.
  always_comb begin
    w_rd_addr = r_col[AW-1:0];
    if (r_state == S_EDGE || (r_state == S_DRAIN && r_col == C_SIZE))
      w_rd_addr = '0;
  end

  assign w_col[0*DATA_WIDTH +: DATA_WIDTH] = r_lb2[w_rd_addr];
  assign w_col[1*DATA_WIDTH +: DATA_WIDTH] = r_lb1[w_rd_addr];
  assign w_col[2*DATA_WIDTH +: DATA_WIDTH] = r_ready ? data_in : '0;

  assign w_mask_top   = (r_state == S_RUN || r_state == S_EDGE) && (r_row == C_ONE);
  assign w_mask_left  = (r_state == S_RUN || r_state == S_DRAIN) && (r_col == C_ONE);
  assign w_mask_right = (r_state == S_EDGE) || (r_state == S_DRAIN && r_col == C_SIZE);
  assign w_mask_bot   = (r_state == S_DRAIN);

  always_comb begin
    w_shift  = '0;
    w_masked = '0;
    for (int r = 0; r < 3; r++) begin
      w_shift[(3*r+0)*DATA_WIDTH +: DATA_WIDTH] = r_win[(3*r+1)*DATA_WIDTH +: DATA_WIDTH];
      w_shift[(3*r+1)*DATA_WIDTH +: DATA_WIDTH] = r_win[(3*r+2)*DATA_WIDTH +: DATA_WIDTH];
      w_shift[(3*r+2)*DATA_WIDTH +: DATA_WIDTH] = w_col[r*DATA_WIDTH +: DATA_WIDTH];
    end
    w_masked = w_shift;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((r == 0 && w_mask_top) || (c == 0 && w_mask_left) ||
            (c == 2 && w_mask_right) || (r == 2 && w_mask_bot))
          w_masked[(3*r+c)*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Line buffers carry no reset; stale words only ever reach masked window positions.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_lb2[w_rd_addr] <= r_lb1[w_rd_addr];
      r_lb1[w_rd_addr] <= data_in;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= S_ROW0;
      r_row      <= '0;
      r_col      <= '0;
      r_ready    <= 1'b1;
      r_win      <= '0;
      window_out <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= w_emit;
      frame_done <= 1'b0;
      if (w_step) r_win <= w_shift;
      if (w_emit) window_out <= w_masked;
      case (r_state)
        S_ROW0: begin
          if (w_accept) begin
            if (r_col == C_LAST) begin
              r_col   <= '0;
              r_row   <= C_ONE;
              r_state <= S_RUN;
            end else begin
              r_col <= r_col + C_ONE;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (r_col == C_LAST) begin
              r_col   <= '0;
              r_ready <= 1'b0;
              r_state <= S_EDGE;
            end else begin
              r_col <= r_col + C_ONE;
            end
          end
        end
        S_EDGE: begin
          if (r_row == C_LAST) begin
            r_col   <= C_ONE;
            r_state <= S_DRAIN;
          end else begin
            r_row   <= r_row + C_ONE;
            r_ready <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (r_col == C_SIZE) begin
            r_col      <= '0;
            r_row      <= '0;
            r_ready    <= 1'b1;
            frame_done <= 1'b1;
            r_state    <= S_ROW0;
          end else begin
            r_col <= r_col + C_ONE;
          end
        end
        default: begin
          r_state <= S_ROW0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_window3x3.sv
// tb/tb_pad_window3x3.sv - randomized self-checking bench for pad_window3x3 (IMG_SIZE 4 and 2)
module tb_pad_window3x3;

  localparam int DW = 32;
  localparam int WW = 9 * DW;

  logic          Clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] d4 = '0, d2 = '0;
  logic          vi4 = 1'b0, vi2 = 1'b0;
  logic          rdy4, rdy2, vo4, vo2, fd4, fd2;
  logic [WW-1:0] w4, w2;

  pad_window3x3 #(.DATA_WIDTH(DW), .IMG_SIZE(4)) u_dut4 (
    .Clk(Clk), .Rst(rst_n), .data_in(d4), .valid_in(vi4), .ready_out(rdy4),
    .window_out(w4), .valid_out(vo4), .frame_done(fd4)
  );

  pad_window3x3 #(.DATA_WIDTH(DW), .IMG_SIZE(2)) u_dut2 (
    .Clk(Clk), .Rst(rst_n), .data_in(d2), .valid_in(vi2), .ready_out(rdy2),
    .window_out(w2), .valid_out(vo2), .frame_done(fd2)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [WW-1:0] win;
    logic          fd;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] img [32];
  exp_t          q4[$], q2[$];
  logic [WW-1:0] cap4[$], cap2[$];
  int            nfd4 = 0, nfd2 = 0;
  logic          gap4_q = 1'b0, gap2_q = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] w9(input int unsigned e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {e8[DW-1:0], e7[DW-1:0], e6[DW-1:0], e5[DW-1:0], e4[DW-1:0],
            e3[DW-1:0], e2[DW-1:0], e1[DW-1:0], e0[DW-1:0]};
  endfunction

  // Window centred on (R,C) of an n x n image stored at img[off..], zero outside the map.
  function automatic logic [WW-1:0] model_win(input int n, input int off, input int R, input int C);
    logic [WW-1:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int y = R + r - 1;
        int x = C + c - 1;
        if (y >= 0 && y < n && x >= 0 && x < n) w[(3*r+c)*DW +: DW] = img[off + y*n + x];
      end
    return w;
  endfunction

  task automatic expect_frame(input int sel, input int n, input int off, input int ncent);
    for (int k = 0; k < ncent; k++) begin
      exp_t e;
      e.win = model_win(n, off, k / n, k % n);
      e.fd  = (k == n*n - 1);
      if (sel == 4) q4.push_back(e);
      else q2.push_back(e);
    end
  endtask

  always @(posedge Clk) begin
    gap4_q <= rst_n && rdy4 && !vi4;
    gap2_q <= rst_n && rdy2 && !vi2;
  end

  always @(negedge Clk) begin
    if (rst_n) begin
      if (vo4) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut4_extra_window: got %h expected no window", w4);
        end else begin
          exp_t e;
          e = q4.pop_front();
          chk("dut4_window", w4, e.win);
          chk("dut4_frame_done", WW'(fd4), WW'(e.fd));
        end
        cap4.push_back(w4);
        if (fd4) nfd4++;
      end else if (fd4) begin
        checks++; errors++;
        $display("FAIL dut4_frame_done_alone: got 1 expected 0");
      end
      if (vo2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut2_extra_window: got %h expected no window", w2);
        end else begin
          exp_t e;
          e = q2.pop_front();
          chk("dut2_window", w2, e.win);
          chk("dut2_frame_done", WW'(fd2), WW'(e.fd));
        end
        cap2.push_back(w2);
        if (fd2) nfd2++;
      end else if (fd2) begin
        checks++; errors++;
        $display("FAIL dut2_frame_done_alone: got 1 expected 0");
      end
      if (gap4_q) chk("dut4_valid_after_gap", WW'(vo4), '0);
      if (gap2_q) chk("dut2_valid_after_gap", WW'(vo2), '0);
    end
  end

  task automatic set_in(input int sel, input logic v, input logic [DW-1:0] d);
    if (sel == 4) begin vi4 = v; d4 = d; end
    else begin vi2 = v; d2 = d; end
  endtask

  task automatic drive(input int sel, input int off, input int npix, input bit gaps);
    bit acc;
    int guard;
    for (int k = 0; k < npix; k++) begin
      if (gaps)
        while ($urandom_range(1, 0) == 0) begin
          set_in(sel, 1'b0, '0);
          @(posedge Clk); #1;
        end
      set_in(sel, 1'b1, img[off + k]);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 64) begin
        @(negedge Clk);
        acc = (sel == 4) ? rdy4 : rdy2;
        @(posedge Clk); #1;
        guard++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL dut%0d_accept_timeout: got no ready expected ready within 64 cycles", sel);
      end
    end
    set_in(sel, 1'b0, '0);
  endtask

  task automatic wait_empty(input int sel);
    int g = 0;
    while (((sel == 4) ? q4.size() : q2.size()) > 0 && g < 200) begin
      @(posedge Clk);
      g++;
    end
    if (((sel == 4) ? q4.size() : q2.size()) > 0) begin
      checks++; errors++;
      $display("FAIL dut%0d_drain_timeout: got %0d pending windows expected 0", sel,
               (sel == 4) ? q4.size() : q2.size());
    end
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic chk_cap(input string name, input int sel, input int idx, input logic [WW-1:0] exp);
    int sz = (sel == 4) ? cap4.size() : cap2.size();
    if (idx < sz) chk(name, (sel == 4) ? cap4[idx] : cap2[idx], exp);
    else begin
      checks++; errors++;
      $display("FAIL %s: got missing window expected %h", name, exp);
    end
  endtask

  initial begin
    int rdy_exp[$];
    int v0, f0, p;
    bit acc;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge Clk);
    chk("reset_ready4", WW'(rdy4), WW'(1));
    chk("reset_valid4", WW'(vo4), '0);
    chk("reset_done4", WW'(fd4), '0);
    chk("reset_window4", w4, '0);
    chk("reset_ready2", WW'(rdy2), WW'(1));
    chk("reset_window2", w2, '0);
    @(posedge Clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) img[k] = DW'(k + 1);
    chk("model_first", model_win(4, 0, 0, 0), w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    chk("model_c11", model_win(4, 0, 1, 1), w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk("model_c03", model_win(4, 0, 0, 3), w9(0, 0, 0, 3, 4, 0, 7, 8, 0));
    chk("model_c33", model_win(4, 0, 3, 3), w9(11, 12, 0, 15, 16, 0, 0, 0, 0));

    // Gap-free frame with a cycle-by-cycle ready_out profile.
    expect_frame(4, 4, 0, 16);
    v0 = cap4.size();
    f0 = nfd4;
    for (int i = 0; i < 4; i++) rdy_exp.push_back(1);
    for (int r = 1; r < 4; r++) begin
      for (int i = 0; i < 4; i++) rdy_exp.push_back(1);
      rdy_exp.push_back(0);
    end
    for (int i = 0; i < 4; i++) rdy_exp.push_back(0);
    rdy_exp.push_back(1);
    p = 0;
    set_in(4, 1'b1, img[0]);
    for (int t = 0; t < 24; t++) begin
      @(negedge Clk);
      chk($sformatf("ready_cycle%0d", t), WW'(rdy4), WW'(rdy_exp[t]));
      acc = rdy4;
      @(posedge Clk); #1;
      if (acc && vi4) begin
        p++;
        set_in(4, 1'b1, (p < 16) ? img[p] : 32'hFFFF_FFFF);
      end
      if (t == 22) set_in(4, 1'b0, '0);
    end
    chk("frameA_pixels_taken", WW'(p), WW'(16));
    wait_empty(4);
    chk("frameA_window_count", WW'(cap4.size() - v0), WW'(16));
    chk("frameA_done_count", WW'(nfd4 - f0), WW'(1));
    chk_cap("frameA_first", 4, v0, w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    chk_cap("frameA_c11", 4, v0 + 5, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk_cap("frameA_c03", 4, v0 + 3, w9(0, 0, 0, 3, 4, 0, 7, 8, 0));
    chk_cap("frameA_c33", 4, v0 + 15, w9(11, 12, 0, 15, 16, 0, 0, 0, 0));

    // Random pixel values with random input gaps.
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 16; k++) img[k] = $urandom;
      expect_frame(4, 4, 0, 16);
      drive(4, 0, 16, 1'b1);
      wait_empty(4);
    end

    // Abort after pixel 9: only the row-0 centres come out, then a fresh frame.
    for (int k = 0; k < 16; k++) img[k] = DW'(k + 1);
    expect_frame(4, 4, 0, 4);
    f0 = nfd4;
    drive(4, 0, 9, 1'b0);
    repeat (3) @(posedge Clk);
    #1;
    chk("abort_windows_out", WW'(q4.size()), '0);
    rst_n = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    rst_n = 1'b1;
    chk("abort_no_frame_done", WW'(nfd4 - f0), '0);
    for (int k = 0; k < 16; k++) img[k] = DW'(101 + k);
    v0 = cap4.size();
    expect_frame(4, 4, 0, 16);
    drive(4, 0, 16, 1'b0);
    wait_empty(4);
    chk_cap("after_reset_first", 4, v0, w9(0, 0, 0, 0, 101, 102, 0, 105, 106));

    // Back-to-back 2x2 frames.
    for (int k = 0; k < 8; k++) img[k] = DW'(k + 1);
    chk("model_b2b_first", model_win(2, 4, 0, 0), w9(0, 0, 0, 0, 5, 6, 0, 7, 8));
    expect_frame(2, 2, 0, 4);
    expect_frame(2, 2, 4, 4);
    v0 = cap2.size();
    f0 = nfd2;
    drive(2, 0, 8, 1'b0);
    wait_empty(2);
    chk("b2b_window_count", WW'(cap2.size() - v0), WW'(8));
    chk("b2b_done_count", WW'(nfd2 - f0), WW'(2));
    chk_cap("b2b_frame2_first", 2, v0 + 4, w9(0, 0, 0, 0, 5, 6, 0, 7, 8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
